id_stage: RTL
=============

# id_stage

Instruction-decode stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. It latches PC and instruction from fetch into the IF/ID register and owns the 32×32 register file. It decodes operands, immediates and control, detects load-use hazards, and presents a registered ID/EX bundle to the execute stage. It also drives the fetch stall, and accepts flushes from execute and register writes from writeback.

## Interface
- XLEN, 32, datapath width
- NREGS, 32, architectural registers; x0 hardwired to zero

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- if_pc  in  32  PC of the fetched instruction
- if_instruction  in  32  fetched instruction word
- if_valid  in  1  fetch output is a real instruction
- flush  in  1  branch/jump taken in EX; kill IF/ID and ID/EX contents
- ex_mem_read  in  1  instruction currently in EX is a load
- ex_rd  in  5  destination of the instruction in EX
- wb_we, wb_rd, wb_data  in  1/5/32  writeback port
- stall_if  out  1  hold PC and fetch output (combinational)
- id_valid  out  1  ID/EX bundle valid
- id_pc, id_rs1_data, id_rs2_data, id_imm  out  32 each
- id_rs1, id_rs2, id_rd  out  5 each
- id_funct3  out  3; id_funct7b5  out  1
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump, id_jalr, id_lui, id_auipc, id_illegal  out  1 each

## Operation
- IF/ID register holds the pc, instr and valid fields.
  - Loads on every edge unless a stall is active.
  - On flush it loads valid=0.
- Decode is combinational from IF/ID.
  - Opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
  - Any other opcode with valid=1 sets id_illegal=1 and zeroes all other controls.
- Immediates:
  - I, S, B and J formats are sign-extended from bit 31.
  - U format is instr[31:12]<<12.
  - B and J immediates have bit 0 = 0.
  - R-type immediate is 0.
- Register file:
  - Two asynchronous read ports and one synchronous write port.
  - A write to x0 is discarded.
  - Write-first bypass: if wb_we and wb_rd==rs (rs≠0), the read returns wb_data in the same cycle.
- Hazard: stall_if = ifid_valid & ex_mem_read & ex_rd≠0 & (ex_rd==rs1 | (ex_rd==rs2 & instruction uses rs2)).
  - rs2 is used by R, store and branch instructions.
- ID/EX register:
  - Normal cycle: loads the decoded bundle.
  - Stall cycle: loads a bubble (id_valid=0, all control bits 0, data fields don't-care but held at 0).
  - Flush cycle: loads a bubble.
- Priority: reset > flush > stall > normal. When flush and stall coincide, flush wins and stall_if=0.

## Timing
- Latency: an instruction presented by fetch before edge N appears on the id_* outputs after edge N+1 (two registers).
- Load-use stall lasts exactly one cycle, assuming EX advances.
  - IF/ID holds its contents.
  - One bubble is inserted.
  - The next cycle the same instruction re-decodes with ex_mem_read deasserted.
- stall_if is combinational and valid in the same cycle as the hazard condition. Fetch must sample it before the next edge.
- Reset (async, any time including mid-stall):
  - IF/ID and ID/EX are cleared.
  - All 31 writable registers are cleared to 0.
  - Every output is 0, and stall_if is 0.
  - Operation resumes on the first edge after rst rises.
- wb_data is written on the edge where wb_we=1. A same-cycle read sees it via the bypass.

## Structure
- Shared package (riscv_pkg): opcode constants, the immediate-format enum, the ID/EX bundle struct, XLEN.
- Sub-module: regfile (2R1W, bypass, x0 hardwired, async-reset clear).
- Decode, immediate generation and hazard detection stay inline in id_stage.

## Test plan
- addi x1,x0,5 (0x00500093), if_valid=1 → two edges later:
  - id_valid=1, id_rd=1, id_imm=5, id_reg_write=1, id_alu_src=1, id_pc equal to the input pc.
- Regfile bypass: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF.
  - Same cycle, decode add x6,x5,x0 → id_rs1_data=0xDEADBEEF.
  - A write to x0 leaves x0 reading as 0.
- Load-use: ex_mem_read=1 and ex_rd=2 (lw x2,0(x1), 0x0000A103), while ID holds add x3,x2,x1 (0x001101B3):
  - stall_if=1 for one cycle and one bubble is inserted.
  - After the stall, the add issues with id_valid=1, and the IF/ID pc is unchanged across the stall.
- beq x0,x0,-4 (0xFE000EE3) → id_imm=0xFFFFFFFC, id_branch=1, id_reg_write=0.
- Flush coincident with a load-use stall:
  - stall_if=0, next edge id_valid=0, following edge id_valid=0.
- Reset: assert rst=0 mid-stream, mid-stall → all outputs 0 immediately. After release, the x1 read returns 0.
- Undefined opcode 0x0000007F → id_illegal=1, all other controls 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I decode stage.
//   - XLEN / NREGS / register-address width
//   - base opcode constants
//   - immediate-format enum and the immediate generator
//   - control-bit struct and the ID/EX bundle struct
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic jump;
        logic jalr;
        logic lui;
        logic auipc;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        ctrl_t             ctrl;
    } idex_t;

    // The opcode field carries no immediate bits, so only instr[31:7] is taken.
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] ins, input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x XLEN architectural register file, two asynchronous read ports and
// one synchronous write port. x0 is hardwired to zero and ignores writes.
// A write in flight is forwarded to a same-cycle read of that register.
// All writable registers clear on the asynchronous active-low reset.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   raddr1_i/rdata1_o        read port 1
//   raddr2_i/rdata2_o        read port 2
//   we_i, waddr_i, wdata_i   write port
module regfile
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [XLEN-1:0]   rdata1_o,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    // Read view of the whole file; entry 0 is a constant zero.
    logic [XLEN-1:0] rf_view [NREGS];

    assign rf_view[0] = '0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] reg_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    reg_q <= '0;
                end else if (we_i && (waddr_i == REG_AW'(gi))) begin
                    reg_q <= wdata_i;
                end
            end

            assign rf_view[gi] = reg_q;
        end
    endgenerate

    // Write-first forwarding; x0 never forwards.
    always_comb begin
        rdata1_o = rf_view[raddr1_i];
        if (we_i && (raddr1_i != '0) && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        rdata2_o = rf_view[raddr2_i];
        if (we_i && (raddr2_i != '0) && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
// Holds the IF/ID register, owns the register file, decodes operands,
// immediates and control, detects load-use hazards and drives a registered
// ID/EX bundle.
// Ports:
//   clk, rst (async active-low)
//   if_pc/if_instruction/if_valid    from fetch
//   flush                            taken branch/jump in EX: kill IF/ID and ID/EX
//   ex_mem_read/ex_rd                load currently in EX (hazard detection)
//   wb_we/wb_rd/wb_data              writeback port
//   stall_if                         combinational stall request to fetch
//   id_*                             registered ID/EX bundle to execute
module id_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_instruction,
    input  logic              if_valid,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_if,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_rs1_data,
    output logic [XLEN-1:0]   id_rs2_data,
    output logic [XLEN-1:0]   id_imm,
    output logic [REG_AW-1:0] id_rs1,
    output logic [REG_AW-1:0] id_rs2,
    output logic [REG_AW-1:0] id_rd,
    output logic [2:0]        id_funct3,
    output logic              id_funct7b5,
    output logic              id_reg_write,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_mem_to_reg,
    output logic              id_alu_src,
    output logic              id_branch,
    output logic              id_jump,
    output logic              id_jalr,
    output logic              id_lui,
    output logic              id_auipc,
    output logic              id_illegal
);

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            hazard;

    // Flush beats a hazard: the stalled instruction is being killed anyway.
    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (flush) begin
            ifid_pc_d    = if_pc;
            ifid_instr_d = if_instruction;
            ifid_valid_d = 1'b0;
        end else if (!hazard) begin
            ifid_pc_d    = if_pc;
            ifid_instr_d = if_instruction;
            ifid_valid_d = if_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Field extraction and control decode
    // ------------------------------------------------------------------
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
    imm_fmt_e          imm_fmt;
    logic              uses_rs2;

    assign opcode = ifid_instr_q[6:0];
    assign rd     = ifid_instr_q[11:7];
    assign rs1    = ifid_instr_q[19:15];
    assign rs2    = ifid_instr_q[24:20];

    always_comb begin
        ctrl     = '0;
        imm_fmt  = IMM_R;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_R: begin
                ctrl.reg_write = 1'b1;
                uses_rs2       = 1'b1;
            end
            OPC_I_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_fmt        = IMM_I;
            end
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                imm_fmt         = IMM_I;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_fmt        = IMM_S;
                uses_rs2       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                imm_fmt     = IMM_B;
                uses_rs2    = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                imm_fmt        = IMM_J;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_fmt        = IMM_I;
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.lui       = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_fmt        = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.auipc     = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_fmt        = IMM_U;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        // An empty slot carries no control, not even the illegal flag.
        if (!ifid_valid_q) begin
            ctrl = '0;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    regfile u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst),
        .raddr1_i (rs1),
        .rdata1_o (rs1_data),
        .raddr2_i (rs2),
        .rdata2_o (rs2_data),
        .we_i     (wb_we),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data)
    );

    // ------------------------------------------------------------------
    // Load-use hazard. rs1 is compared for every opcode; rs2 only where the
    // instruction actually reads it.
    // ------------------------------------------------------------------
    assign hazard   = ifid_valid_q && ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == rs1) || ((ex_rd == rs2) && uses_rs2));
    assign stall_if = hazard && !flush;

    // ------------------------------------------------------------------
    // ID/EX register. Flush, stall and empty slots all load an all-zero
    // bubble so the data fields never carry stale values.
    // ------------------------------------------------------------------
    idex_t idex_q, idex_d;

    always_comb begin
        idex_d = '0;
        if (ifid_valid_q && !flush && !hazard) begin
            idex_d.valid    = 1'b1;
            idex_d.pc       = ifid_pc_q;
            idex_d.rs1_data = rs1_data;
            idex_d.rs2_data = rs2_data;
            idex_d.imm      = imm_gen(ifid_instr_q[31:7], imm_fmt);
            idex_d.rs1      = rs1;
            idex_d.rs2      = rs2;
            idex_d.rd       = rd;
            idex_d.funct3   = ifid_instr_q[14:12];
            idex_d.funct7b5 = ifid_instr_q[30];
            idex_d.ctrl     = ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign id_valid      = idex_q.valid;
    assign id_pc         = idex_q.pc;
    assign id_rs1_data   = idex_q.rs1_data;
    assign id_rs2_data   = idex_q.rs2_data;
    assign id_imm        = idex_q.imm;
    assign id_rs1        = idex_q.rs1;
    assign id_rs2        = idex_q.rs2;
    assign id_rd         = idex_q.rd;
    assign id_funct3     = idex_q.funct3;
    assign id_funct7b5   = idex_q.funct7b5;
    assign id_reg_write  = idex_q.ctrl.reg_write;
    assign id_mem_read   = idex_q.ctrl.mem_read;
    assign id_mem_write  = idex_q.ctrl.mem_write;
    assign id_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign id_alu_src    = idex_q.ctrl.alu_src;
    assign id_branch     = idex_q.ctrl.branch;
    assign id_jump       = idex_q.ctrl.jump;
    assign id_jalr       = idex_q.ctrl.jalr;
    assign id_lui        = idex_q.ctrl.lui;
    assign id_auipc      = idex_q.ctrl.auipc;
    assign id_illegal    = idex_q.ctrl.illegal;

endmodule
